// File: rtl/uc_pkg.sv
// Shared constants and types for the SRAM arbiter: data width, port identities
// and the read-tag record carried down the read-return pipeline.
package uc_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DBG  = 1'b1
  } port_e;

  typedef struct packed {
    logic  vld;
    port_e port;
  } rd_tag_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way grant picker: round-robin on conflict (PRIO_MODE=0) or fixed core
// priority (PRIO_MODE=1). Purely combinational.
module rr_pick2
  import uc_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic  req_core,
  input  logic  req_dbg,
  input  port_e last_gnt,
  output logic  gnt_core,
  output logic  gnt_dbg
);

  logic core_first;

  always_comb begin
    core_first = (PRIO_MODE != 0) || (last_gnt == PORT_DBG);
    gnt_core   = req_core && (!req_dbg || core_first);
    gnt_dbg    = req_dbg && !gnt_core;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates a core port and a debug/DMA port onto one single-port SRAM with
// a registered command stage and an in-order, tagged read-return pipeline.
module sram_arbiter
  import uc_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_write_en,
  output logic [DATA_W-1:0] sram_data_out,
  input  logic [DATA_W-1:0] sram_data_in
);

  port_e             last_gnt;
  port_e             acc_port;
  logic              pick_core;
  logic              pick_dbg;
  logic              acc_core;
  logic              acc_dbg;
  logic              acc;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  rd_tag_t           tag_nxt;
  rd_tag_t           tag_p0;
  rd_tag_t           tag_p1;

  rr_pick2 #(
    .PRIO_MODE(PRIO_MODE)
  ) u_pick (
    .req_core(c_req),
    .req_dbg (d_req),
    .last_gnt(last_gnt),
    .gnt_core(pick_core),
    .gnt_dbg (pick_dbg)
  );

  // Grants are forced low while reset is held, even though they are combinational.
  assign c_gnt    = pick_core & arst_n;
  assign d_gnt    = pick_dbg & arst_n;
  assign acc_core = c_req & c_gnt;
  assign acc_dbg  = d_req & d_gnt;
  assign acc      = acc_core | acc_dbg;
  assign acc_port = acc_dbg ? PORT_DBG : PORT_CORE;

  always_comb begin
    sel_addr  = c_addr;
    sel_we    = c_we;
    sel_wdata = c_wdata;
    if (acc_dbg) begin
      sel_addr  = d_addr;
      sel_we    = d_we;
      sel_wdata = d_wdata;
    end
    tag_nxt.vld  = acc & ~sel_we;
    tag_nxt.port = acc_port;
  end

  // Stage p0: accepted command drives the SRAM; read tag enters the pipeline.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      last_gnt      <= PORT_DBG;
      sram_addr     <= '0;
      sram_data_out <= '0;
      sram_write_en <= 1'b0;
      tag_p0        <= '0;
    end else begin
      sram_write_en <= acc & sel_we;
      tag_p0        <= tag_nxt;
      if (acc) begin
        last_gnt      <= acc_port;
        sram_addr     <= sel_addr;
        sram_data_out <= sel_wdata;
      end
    end
  end

  // Stage p1: tag aligned with sram_data_in; return registers steer it to the owner.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tag_p1   <= '0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      tag_p1   <= tag_p0;
      c_rvalid <= tag_p1.vld && (tag_p1.port == PORT_CORE);
      d_rvalid <= tag_p1.vld && (tag_p1.port == PORT_DBG);
      if (tag_p1.vld && (tag_p1.port == PORT_CORE)) c_rdata <= sram_data_in;
      if (tag_p1.vld && (tag_p1.port == PORT_DBG))  d_rdata <= sram_data_in;
    end
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter PRIO_MODE, default 0, meaning 0 = round-robin and 1 = fixed priority to core port.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning SRAM address width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port arst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have ports c_req, c_we, input, 1 bit each: core request and core write-not-read.
REQ-006 SHALL have ports c_addr (ADDR_W) and c_wdata (8), input: core address and write data.
REQ-007 SHALL have ports c_gnt, c_rvalid, output, 1 bit each: core accept and core read-data valid.
REQ-008 SHALL have port c_rdata, output, 8 bits: core read data.
REQ-009 SHALL have ports d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: the debug/DMA port, with the same widths and directions as the core port.
REQ-010 SHALL have port sram_addr, output, ADDR_W bits: SRAM address.
REQ-011 SHALL have port sram_write_en, output, 1 bit: SRAM write strobe.
REQ-012 SHALL have port sram_data_out, output, 8 bits: SRAM write data.
REQ-013 SHALL have port sram_data_in, input, 8 bits: SRAM read data, valid one cycle after the address is presented.

Function
REQ-014 SHALL accept at most one request per cycle; x_gnt is combinational from x_req and the arbiter state, and a transfer occurs in any cycle where x_req and x_gnt are both high.
REQ-015 SHALL, when only one port requests, grant that port in the same cycle.
REQ-016 SHALL, when both ports request and PRIO_MODE=0, grant the port not granted most recently; last_gnt resets to debug, so core wins the first conflict.
REQ-017 SHALL, when both ports request and PRIO_MODE=1, always grant the core port.
REQ-018 SHALL update last_gnt only on an accepted transfer.
REQ-019 SHALL register the accepted transfer's addr, we and wdata onto sram_addr, sram_write_en and sram_data_out in cycle N+1 for acceptance in cycle N.
REQ-020 SHALL pulse sram_write_en for exactly one cycle per accepted write.
REQ-021 SHALL hold sram_addr and sram_data_out at their last values and drive sram_write_en=0 when no transfer is accepted.
REQ-022 SHALL carry a read tag (valid and port id) through two pipeline stages.
REQ-023 SHALL, for a read accepted in cycle N, capture sram_data_in at the end of N+2 and assert the owner's rvalid with rdata in cycle N+3 for exactly one cycle.
REQ-024 SHALL support back-to-back reads at one per cycle; returns stay in order, with one rvalid per accepted read.
REQ-025 SHALL preserve access order across ports: a read accepted the cycle after a write to the same address returns the written data.
REQ-026 SHALL leave x_rdata holding its last value when x_rvalid is low.
REQ-027 SHALL never assert c_rvalid and d_rvalid in the same cycle.
REQ-028 SHALL not require a requester to hold x_req after a grant; holding x_req issues another transfer.

Reset
REQ-029 SHALL, while arst_n is low, drive the following: c_gnt=d_gnt=0, sram_write_en=0, sram_addr=0, sram_data_out=0, rvalid outputs 0, rdata outputs 0, read-tag pipeline cleared, last_gnt=debug.
REQ-030 SHALL discard reads in flight when reset asserts mid-operation; no rvalid appears after reset deasserts for them.
REQ-031 SHALL accept requests in the first clock edge after arst_n deasserts.

Structure
REQ-032 SHALL take its port-id constants (PORT_CORE=0, PORT_DBG=1) and the read-tag record width from the shared package uc_pkg.
REQ-033 SHALL implement the grant decision in one sub-module, rr_pick2, a 2-way round-robin/priority picker.
REQ-034 SHALL keep all pipeline registers in the top module.

Verification
REQ-035 SHALL cover a single core write: c_req=1, c_we=1, addr=0x10, wdata=0xA5 at N -> c_gnt=1 at N; sram_write_en=1, sram_addr=0x10, sram_data_out=0xA5 at N+1 only.
REQ-036 SHALL cover a conflict in PRIO_MODE=0: both ports read, held for 4 cycles from reset -> grants C, D, C, D, with rvalid alternating c/d at N+3 through N+6.
REQ-037 SHALL cover a conflict in PRIO_MODE=1: both ports request for 4 cycles -> c_gnt=1 every cycle and d_gnt=0.
REQ-038 SHALL cover write-then-read: d writes 0x3C to 0x20 at N, c reads 0x20 at N+1 -> c_rvalid=1, c_rdata=0x3C at N+4.
REQ-039 SHALL cover reset mid-read: a read is accepted at N and arst_n goes low at N+1 -> no rvalid afterward; all outputs at reset values.
REQ-040 SHALL cover streaming: 8 consecutive core reads 0x00..0x07 -> 8 consecutive c_rvalid cycles with data in address order.
